// File: rtl/qrs_peak_search.sv
// QRS candidate detector: lagged absolute difference, running maximum, threshold arming,
// windowed peak localisation with a single report pulse and refractory blanking.
module qrs_peak_search #(
  parameter int DATA_WIDTH  = 11,
  parameter int CTR_WIDTH   = 24,
  parameter int DIFF_DIST   = 4,
  parameter int SEARCH_WIN  = 36,
  parameter int REFRACT_LEN = 72
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_qrs_search_en,
  input  logic [DATA_WIDTH-1:0] i_qrs_threshold,
  output logic [CTR_WIDTH-1:0]  o_ctr,
  output logic [DATA_WIDTH-1:0] o_abs_diff_short_max,
  output logic                  o_abs_diff_short_valid,
  output logic                  o_extremum_found,
  output logic [CTR_WIDTH-1:0]  o_peak_idx
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam int FILL_W = $clog2(DIFF_DIST + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
  localparam int REF_W  = $clog2(REFRACT_LEN + 1);

  typedef enum logic [2:0] {ACQ, ARMED, PEAK, REPORT, REFRACT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] delay_line [DIFF_DIST];
  logic [FILL_W-1:0]     fill;
  logic [WIN_W-1:0]      win;
  logic [REF_W-1:0]      ref_cnt;

  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0]        diff_mag;
  logic [DATA_WIDTH-1:0]      d;
  logic                       d_valid;

  // Full-width difference of sign-extended samples cannot overflow; only the magnitude is clipped.
  always_comb begin
    diff     = $signed({i_sample[DATA_WIDTH-1], i_sample})
             - $signed({delay_line[DIFF_DIST-1][DATA_WIDTH-1], delay_line[DIFF_DIST-1]});
    diff_mag = diff[DATA_WIDTH] ? unsigned'(-diff) : unsigned'(diff);
    d        = (diff_mag > {1'b0, SAT_MAX}) ? SAT_MAX : diff_mag[DATA_WIDTH-1:0];
    d_valid  = i_ce && (fill == FILL_W'(DIFF_DIST));
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < DIFF_DIST; k++) delay_line[k] <= '0;
      fill <= '0;
    end else if (i_ce) begin
      delay_line[0] <= i_sample;
      for (int k = 1; k < DIFF_DIST; k++) delay_line[k] <= delay_line[k-1];
      if (fill != FILL_W'(DIFF_DIST)) fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state                  <= ACQ;
      o_ctr                  <= '0;
      o_abs_diff_short_max   <= '0;
      o_abs_diff_short_valid <= 1'b0;
      o_extremum_found       <= 1'b0;
      o_peak_idx             <= '0;
      win                    <= '0;
      ref_cnt                <= '0;
    end else begin
      o_extremum_found <= 1'b0;
      if (i_ce) o_ctr <= o_ctr + 1'b1;
      if (d_valid) o_abs_diff_short_valid <= 1'b1;
      case (state)
        ACQ: begin
          if (i_qrs_search_en) begin
            state                <= ARMED;
            o_abs_diff_short_max <= '0;
          end else if (d_valid && (d > o_abs_diff_short_max)) begin
            o_abs_diff_short_max <= d;
          end
        end
        ARMED: begin
          if (!i_qrs_search_en) begin
            state <= ACQ;
          end else if (d_valid && (d >= i_qrs_threshold)) begin
            state                <= PEAK;
            o_abs_diff_short_max <= d;
            o_peak_idx           <= o_ctr;
            win                  <= WIN_W'(1);
          end
        end
        // Strict compare keeps the earliest index when the maximum repeats.
        PEAK: begin
          if (!i_qrs_search_en) begin
            state <= ACQ;
          end else if (d_valid) begin
            if (d > o_abs_diff_short_max) begin
              o_abs_diff_short_max <= d;
              o_peak_idx           <= o_ctr;
            end
            win <= win + 1'b1;
            if (win == WIN_W'(SEARCH_WIN - 1)) begin
              state            <= REPORT;
              o_extremum_found <= 1'b1;
            end
          end
        end
        REPORT: begin
          state   <= REFRACT;
          ref_cnt <= '0;
        end
        REFRACT: begin
          if (i_ce) begin
            ref_cnt <= ref_cnt + 1'b1;
            if (ref_cnt == REF_W'(REFRACT_LEN - 1)) begin
              o_abs_diff_short_max <= '0;
              state                <= i_qrs_search_en ? ARMED : ACQ;
            end
          end
        end
        default: state <= ACQ;
      endcase
    end
  end

endmodule

// File: tb/tb_qrs_peak_search.sv
// Scoreboard bench for qrs_peak_search: directed scenarios then random ECG-like stimulus,
// checked against a sample-level reference model of the detector rules.
module tb_qrs_peak_search;

  localparam int DW  = 11;
  localparam int CW  = 12;
  localparam int DD  = 4;
  localparam int SW  = 36;
  localparam int RL  = 72;
  localparam int SAT = (1 << (DW - 1)) - 1;

  logic                 i_clk = 1'b0;
  logic                 i_nrst = 1'b0;
  logic                 i_ce = 1'b0;
  logic signed [DW-1:0] i_sample = '0;
  logic                 i_qrs_search_en = 1'b0;
  logic [DW-1:0]        i_qrs_threshold = '0;
  logic [CW-1:0]        o_ctr;
  logic [DW-1:0]        o_abs_diff_short_max;
  logic                 o_abs_diff_short_valid;
  logic                 o_extremum_found;
  logic [CW-1:0]        o_peak_idx;

  qrs_peak_search #(
    .DATA_WIDTH(DW), .CTR_WIDTH(CW), .DIFF_DIST(DD), .SEARCH_WIN(SW), .REFRACT_LEN(RL)
  ) dut (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .i_ce(i_ce),
    .i_sample(i_sample),
    .i_qrs_search_en(i_qrs_search_en),
    .i_qrs_threshold(i_qrs_threshold),
    .o_ctr(o_ctr),
    .o_abs_diff_short_max(o_abs_diff_short_max),
    .o_abs_diff_short_valid(o_abs_diff_short_valid),
    .o_extremum_found(o_extremum_found),
    .o_peak_idx(o_peak_idx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int ctr; int mx; bit vld; bit pulse; } sample_exp_t;
  typedef struct { int idx; int mx; int ctr; } pulse_exp_t;

  sample_exp_t sample_q[$];
  pulse_exp_t  pulse_q[$];
  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;

  // Reference model: detector phases over a history of the last DD samples
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_WINDOW = 2, PH_BLANK = 3;
  int m_phase, m_ctr, m_max, m_peak, m_seen, m_blank_left;
  bit m_valid;
  int m_hist[$];

  function automatic void modelReset();
    m_phase = PH_IDLE; m_ctr = 0; m_max = 0; m_peak = 0; m_seen = 0; m_blank_left = 0;
    m_valid = 1'b0;
    m_hist.delete();
  endfunction

  function automatic void modelEdge(input bit ce, input int x, input bit en, input int thr);
    bit dv = 1'b0;
    bit end_win = 1'b0;
    int d = 0;
    int idx = m_ctr;
    if (ce) begin
      if (m_hist.size() == DD) begin
        dv = 1'b1;
        d = x - m_hist[0];
        if (d < 0) d = -d;
        if (d > SAT) d = SAT;
      end
      m_hist.push_back(x);
      if (m_hist.size() > DD) void'(m_hist.pop_front());
      m_ctr = (m_ctr + 1) % (1 << CW);
      m_valid = m_valid | dv;
    end
    case (m_phase)
      PH_IDLE: begin
        if (en) begin m_phase = PH_ARMED; m_max = 0; end
        else if (dv && d > m_max) m_max = d;
      end
      PH_ARMED: begin
        if (!en) m_phase = PH_IDLE;
        else if (dv && d >= thr) begin
          m_phase = PH_WINDOW; m_max = d; m_peak = idx; m_seen = 1;
        end
      end
      PH_WINDOW: begin
        if (!en) m_phase = PH_IDLE;
        else if (dv) begin
          if (d > m_max) begin m_max = d; m_peak = idx; end
          m_seen++;
          if (m_seen == SW) begin
            end_win = 1'b1;
            pulse_q.push_back('{m_peak, m_max, m_ctr});
            m_phase = PH_BLANK;
            m_blank_left = RL;
          end
        end
      end
      default: begin
        if (ce) begin
          m_blank_left--;
          if (m_blank_left == 0) begin
            m_max = 0;
            m_phase = en ? PH_ARMED : PH_IDLE;
          end
        end
      end
    endcase
    if (ce) sample_q.push_back('{m_ctr, m_max, m_valid, end_win});
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One sample step: optional enable change on a quiet clock, the strobe clock, a quiet clock.
  task automatic applyStimulus(input int x, input bit en, input bit en_with_ce);
    logic signed [DW-1:0] xs;
    xs = DW'(x);
    if (!en_with_ce) begin
      i_qrs_search_en = en;
      modelEdge(1'b0, 0, en, int'(i_qrs_threshold));
      @(posedge i_clk); #2;
    end
    i_ce = 1'b1; i_sample = xs; i_qrs_search_en = en;
    modelEdge(1'b1, int'(xs), en, int'(i_qrs_threshold));
    @(posedge i_clk); #2;
    i_ce = 1'b0;
    modelEdge(1'b0, 0, en, int'(i_qrs_threshold));
    @(posedge i_clk); #2;
  endtask

  task automatic applyReset(input string tag);
    i_ce = 1'b0; i_qrs_search_en = 1'b0; i_nrst = 1'b0;
    #2;
    checkOutput({tag, "_rst_ctr"}, o_ctr, 0);
    checkOutput({tag, "_rst_max"}, o_abs_diff_short_max, 0);
    checkOutput({tag, "_rst_valid"}, o_abs_diff_short_valid, 0);
    checkOutput({tag, "_rst_found"}, o_extremum_found, 0);
    checkOutput({tag, "_rst_peak"}, o_peak_idx, 0);
    modelReset();
    sample_q.delete();
    pulse_q.delete();
    @(posedge i_clk); #2;
    i_nrst = 1'b1;
    @(posedge i_clk); #2;
  endtask

  // Monitor: per accepted sample and per report pulse
  initial begin
    bit ce_seen;
    sample_exp_t se;
    pulse_exp_t pe;
    forever begin
      @(posedge i_clk);
      ce_seen = i_ce;
      @(negedge i_clk);
      if (ce_seen && i_nrst) begin
        if (sample_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL sample_queue: DUT accepted a sample with no expectation queued");
        end else begin
          se = sample_q.pop_front();
          checkOutput("ctr", o_ctr, se.ctr);
          checkOutput("max", o_abs_diff_short_max, se.mx);
          checkOutput("valid", o_abs_diff_short_valid, se.vld);
          checkOutput("found_timing", o_extremum_found, se.pulse);
        end
      end
      if (o_extremum_found === 1'b1) begin
        pulses_seen++;
        if (pulse_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL pulse_queue: unexpected pulse, peak_idx=%0d expected none", o_peak_idx);
        end else begin
          pe = pulse_q.pop_front();
          checkOutput("pulse_peak_idx", o_peak_idx, pe.idx);
          checkOutput("pulse_max", o_abs_diff_short_max, pe.mx);
          checkOutput("pulse_ctr", o_ctr, pe.ctr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int x;
    bit en;
    modelReset();
    @(posedge i_clk); #2;

    // Priming and running max with search disabled
    $display("[TB] directed: priming and running max");
    applyReset("t1");
    i_qrs_threshold = '0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b0);
    checkOutput("t1_valid_before", o_abs_diff_short_valid, 0);
    applyStimulus(100, 1'b0, 1'b0);
    checkOutput("t1_valid_after", o_abs_diff_short_valid, 1);
    checkOutput("t1_ctr", o_ctr, 5);
    applyStimulus(-300, 1'b0, 1'b0);
    checkOutput("t2_max", o_abs_diff_short_max, 300);

    $display("[TB] directed: saturation");
    applyReset("t3");
    for (int i = 0; i < 4; i++) applyStimulus(-1024, 1'b0, 1'b0);
    applyStimulus(1023, 1'b0, 1'b0);
    checkOutput("t3_sat_max", o_abs_diff_short_max, 1023);

    $display("[TB] directed: localisation and refractory");
    applyReset("t4");
    i_qrs_threshold = 11'd200;
    for (int i = 0; i < 130; i++) begin
      x = (i < 8) ? 0 : (i < 13) ? 250 : (i < 60) ? 650 : 150;
      applyStimulus(x, 1'b1, 1'b0);
    end
    checkOutput("t4_peak_idx", o_peak_idx, 13);
    checkOutput("t4_armed_max", o_abs_diff_short_max, 0);

    $display("[TB] directed: search disabled mid-window");
    applyReset("t5");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(300, 1'b1, 1'b0);
    applyStimulus(300, 1'b0, 1'b0);
    checkOutput("t5_max_kept", o_abs_diff_short_max, 300);
    applyStimulus(300, 1'b1, 1'b0);
    checkOutput("t5_rearm_max", o_abs_diff_short_max, 0);

    $display("[TB] directed: reset during refractory");
    applyReset("t6a");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 1'b0);
    for (int i = 0; i < 46; i++) applyStimulus(300, 1'b1, 1'b0);
    applyReset("t6");

    $display("[TB] random phase with counter wrap");
    x = 0;
    en = 1'b0;
    for (int n = 0; n < (1 << CW) + 300; n++) begin
      if ($urandom_range(0, 49) == 0) x = int'($urandom_range(0, 2047)) - 1024;
      else x = x + int'($urandom_range(0, 300)) - 150;
      if (x > 1023) x = 1023;
      if (x < -1024) x = -1024;
      if ($urandom_range(0, 99) == 0)
        i_qrs_threshold = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(100, 700));
      if ($urandom_range(0, 29) == 0) en = ~en;
      applyStimulus(x, en, 1'($urandom_range(0, 1)));
      if (n == (1 << CW) - 1) checkOutput("ctr_wrap", o_ctr, 0);
    end

    repeat (4) @(posedge i_clk);
    #2;
    checkOutput("pending_pulses", pulse_q.size(), 0);
    checkOutput("pending_samples", sample_q.size(), 0);
    checkOutput("any_pulse", (pulses_seen > 0) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
